// File: rtl/fsm_ctrl_if.sv
// rtl/fsm_ctrl_if.sv - keyboard command / piece position bundle for fsm_ctrl
interface fsm_ctrl_if;
  logic [29:0] scancode;
  logic [3:0]  xpos_int;
  logic [3:0]  ypos_int;
  logic [3:0]  next_xpos;
  logic [3:0]  next_ypos;
  logic        out;
  logic        rotate_flag;

  // Keyboard/position source side
  modport master (
    output scancode, xpos_int, ypos_int,
    input  next_xpos, next_ypos, out, rotate_flag
  );

  // Controller side
  modport slave (
    input  scancode, xpos_int, ypos_int,
    output next_xpos, next_ypos, out, rotate_flag
  );
endinterface

// File: rtl/fsm_ctrl.sv
// rtl/fsm_ctrl.sv - piece move/rotate controller; optional FSM_BREAK_FILTER_EN drops key-release codes
module fsm_ctrl (
  input logic        clock,
  input logic        reset,
  fsm_ctrl_if.slave  bus
);

  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_STOP      = 3'd1;
  localparam logic [2:0] S_CHK_DOWN  = 3'd2;
  localparam logic [2:0] S_CHK_LEFT  = 3'd3;
  localparam logic [2:0] S_CHK_RIGHT = 3'd4;
  localparam logic [2:0] S_CHK_ROT   = 3'd5;
  localparam logic [2:0] S_GO_MOVE   = 3'd6;
  localparam logic [2:0] S_GO_ROT    = 3'd7;

  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_STOP   = 3'd1;
  localparam logic [2:0] CMD_DOWN   = 3'd2;
  localparam logic [2:0] CMD_LEFT   = 3'd3;
  localparam logic [2:0] CMD_RIGHT  = 3'd4;
  localparam logic [2:0] CMD_ROTATE = 3'd5;

  localparam logic [7:0] KEY_STOP   = 8'h1B;
  localparam logic [7:0] KEY_DOWN   = 8'h23;
  localparam logic [7:0] KEY_LEFT   = 8'h1C;
  localparam logic [7:0] KEY_RIGHT  = 8'h2B;
  localparam logic [7:0] KEY_ROTATE = 8'h3C;

  logic [2:0] state;
  logic [2:0] cmd;
  logic [7:0] key;

  // Upper scancode bits carry no meaning for this controller
  logic unused_hi;
  assign unused_hi = ^bus.scancode[29:16];

`ifndef FSM_BREAK_FILTER_EN
  logic unused_prefix;
  assign unused_prefix = ^bus.scancode[15:8];
`endif

  assign key = bus.scancode[7:0];

  // Translate the key code into a command; release codes are dropped when filtering
  always_comb begin
    cmd = CMD_NONE;
    case (key)
      KEY_STOP:   cmd = CMD_STOP;
      KEY_DOWN:   cmd = CMD_DOWN;
      KEY_LEFT:   cmd = CMD_LEFT;
      KEY_RIGHT:  cmd = CMD_RIGHT;
      KEY_ROTATE: cmd = CMD_ROTATE;
      default:    cmd = CMD_NONE;
    endcase
`ifdef FSM_BREAK_FILTER_EN
    if (bus.scancode[15:8] == 8'hF0) begin
      cmd = CMD_NONE;
    end
`endif
  end

  // State machine; out/rotate_flag are raised on the edge that enters a GO state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_WAIT;
      bus.next_xpos   <= 4'd0;
      bus.next_ypos   <= 4'd0;
      bus.out         <= 1'b0;
      bus.rotate_flag <= 1'b0;
    end else begin
      bus.out         <= 1'b0;
      bus.rotate_flag <= 1'b0;
      case (state)
        S_WAIT: begin
          bus.next_xpos <= bus.xpos_int;
          bus.next_ypos <= bus.ypos_int;
          case (cmd)
            CMD_STOP:   state <= S_STOP;
            CMD_DOWN:   state <= S_CHK_DOWN;
            CMD_LEFT:   state <= S_CHK_LEFT;
            CMD_RIGHT:  state <= S_CHK_RIGHT;
            CMD_ROTATE: state <= S_CHK_ROT;
            default:    state <= S_WAIT;
          endcase
        end
        S_STOP: begin
          // The exit cycle only returns to WAIT; the new key is sampled there
          if (key != KEY_STOP) begin
            state <= S_WAIT;
          end
        end
        S_CHK_DOWN: begin
          if (bus.ypos_int < 4'd15) begin
            state         <= S_GO_MOVE;
            bus.next_ypos <= bus.ypos_int + 4'd1;
            bus.out       <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_CHK_LEFT: begin
          if (bus.xpos_int > 4'd0) begin
            state         <= S_GO_MOVE;
            bus.next_xpos <= bus.xpos_int - 4'd1;
            bus.out       <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_CHK_RIGHT: begin
          if (bus.xpos_int < 4'd9) begin
            state         <= S_GO_MOVE;
            bus.next_xpos <= bus.xpos_int + 4'd1;
            bus.out       <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_CHK_ROT: begin
          // Rotation needs one free column on each side and one row below
          if ((bus.xpos_int >= 4'd1) && (bus.xpos_int <= 4'd8) &&
              (bus.ypos_int <= 4'd14)) begin
            state           <= S_GO_ROT;
            bus.out         <= 1'b1;
            bus.rotate_flag <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_GO_MOVE: state <= S_WAIT;
        S_GO_ROT:  state <= S_WAIT;
        default:   state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_ctrl.sv
// tb/tb_fsm_ctrl.sv - directed self-checking bench for fsm_ctrl
module tb_fsm_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic exp_break_out;

  fsm_ctrl_if bus ();

  fsm_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [29:0] sc, input logic [3:0] x, input logic [3:0] y);
    bus.scancode = sc;
    bus.xpos_int = x;
    bus.ypos_int = y;
  endtask

  initial begin
    put(30'h0, 4'd7, 4'd2);
    #2;
    check("rst_out", {3'b0, bus.out}, 4'd0);
    check("rst_rot", {3'b0, bus.rotate_flag}, 4'd0);
    check("rst_nx", bus.next_xpos, 4'd0);
    check("rst_ny", bus.next_ypos, 4'd0);
    tick();
    check("rst_hold_nx", bus.next_xpos, 4'd0);
    reset = 1'b1;
    tick();
    check("idle_out", {3'b0, bus.out}, 4'd0);
    check("idle_nx", bus.next_xpos, 4'd7);
    check("idle_ny", bus.next_ypos, 4'd2);

    // DOWN from (4,3)
    put(30'h23, 4'd4, 4'd3);
    tick();
    put(30'h0, 4'd4, 4'd3);
    check("down_chk_out", {3'b0, bus.out}, 4'd0);
    tick();
    check("down_go_out", {3'b0, bus.out}, 4'd1);
    check("down_go_rot", {3'b0, bus.rotate_flag}, 4'd0);
    check("down_go_ny", bus.next_ypos, 4'd4);
    check("down_go_nx", bus.next_xpos, 4'd4);
    tick();
    check("down_end_out", {3'b0, bus.out}, 4'd0);
    check("down_end_ny", bus.next_ypos, 4'd4);

    // LEFT blocked at column 0
    put(30'h1C, 4'd0, 4'd3);
    tick();
    put(30'h0, 4'd0, 4'd3);
    tick();
    check("left0_out", {3'b0, bus.out}, 4'd0);
    check("left0_nx", bus.next_xpos, 4'd0);
    tick();
    check("left0_out2", {3'b0, bus.out}, 4'd0);

    // RIGHT blocked at column 9
    put(30'h2B, 4'd9, 4'd3);
    tick();
    put(30'h0, 4'd9, 4'd3);
    tick();
    check("right9_out", {3'b0, bus.out}, 4'd0);
    check("right9_nx", bus.next_xpos, 4'd9);
    tick();
    check("right9_out2", {3'b0, bus.out}, 4'd0);

    // LEFT allowed from 3, RIGHT allowed from 8
    put(30'h1C, 4'd3, 4'd6);
    tick();
    put(30'h0, 4'd3, 4'd6);
    tick();
    check("left3_out", {3'b0, bus.out}, 4'd1);
    check("left3_nx", bus.next_xpos, 4'd2);
    tick();
    put(30'h2B, 4'd8, 4'd6);
    tick();
    put(30'h0, 4'd8, 4'd6);
    tick();
    check("right8_out", {3'b0, bus.out}, 4'd1);
    check("right8_nx", bus.next_xpos, 4'd9);
    tick();

    // DOWN blocked at bottom row
    put(30'h23, 4'd4, 4'd15);
    tick();
    put(30'h0, 4'd4, 4'd15);
    tick();
    check("down15_out", {3'b0, bus.out}, 4'd0);
    check("down15_ny", bus.next_ypos, 4'd15);
    tick();

    // ROTATE allowed at (5,5)
    put(30'h3C, 4'd5, 4'd5);
    tick();
    put(30'h0, 4'd5, 4'd5);
    tick();
    check("rot_out", {3'b0, bus.out}, 4'd1);
    check("rot_flag", {3'b0, bus.rotate_flag}, 4'd1);
    check("rot_nx", bus.next_xpos, 4'd5);
    check("rot_ny", bus.next_ypos, 4'd5);
    tick();
    check("rot_end_out", {3'b0, bus.out}, 4'd0);
    check("rot_end_flag", {3'b0, bus.rotate_flag}, 4'd0);

    // ROTATE blocked at column 0 and at row 15
    put(30'h3C, 4'd0, 4'd5);
    tick();
    put(30'h0, 4'd0, 4'd5);
    tick();
    check("rot_x0_out", {3'b0, bus.out}, 4'd0);
    check("rot_x0_flag", {3'b0, bus.rotate_flag}, 4'd0);
    tick();
    put(30'h3C, 4'd5, 4'd15);
    tick();
    put(30'h0, 4'd5, 4'd15);
    tick();
    check("rot_y15_out", {3'b0, bus.out}, 4'd0);
    tick();

    // STOP held 3 cycles, then DOWN
    put(30'h1B, 4'd4, 4'd3);
    tick();
    check("stop1_out", {3'b0, bus.out}, 4'd0);
    tick();
    check("stop2_out", {3'b0, bus.out}, 4'd0);
    tick();
    check("stop3_out", {3'b0, bus.out}, 4'd0);
    put(30'h23, 4'd4, 4'd3);
    tick();
    check("stop_exit_out", {3'b0, bus.out}, 4'd0);
    tick();
    check("stop_chk_out", {3'b0, bus.out}, 4'd0);
    put(30'h0, 4'd4, 4'd3);
    tick();
    check("stop_down_out", {3'b0, bus.out}, 4'd1);
    check("stop_down_ny", bus.next_ypos, 4'd4);
    tick();

    // Held DOWN re-triggers every 3 cycles
    put(30'h23, 4'd2, 4'd13);
    tick();
    tick();
    check("hold1_out", {3'b0, bus.out}, 4'd1);
    check("hold1_ny", bus.next_ypos, 4'd14);
    tick();
    check("hold_gap_out", {3'b0, bus.out}, 4'd0);
    tick();
    tick();
    check("hold2_out", {3'b0, bus.out}, 4'd1);
    put(30'h0, 4'd2, 4'd13);
    tick();
    tick();

    // Key release code handling
`ifdef FSM_BREAK_FILTER_EN
    exp_break_out = 1'b0;
`else
    exp_break_out = 1'b1;
`endif
    put(30'h0000F023, 4'd4, 4'd3);
    tick();
    put(30'h0, 4'd4, 4'd3);
    tick();
    check("break_out", {3'b0, bus.out}, {3'b0, exp_break_out});
    tick();
    tick();

    // Reset during a check aborts the move
    put(30'h23, 4'd6, 4'd3);
    tick();
    put(30'h0, 4'd6, 4'd3);
    reset = 1'b0;
    #1;
    check("abort_out", {3'b0, bus.out}, 4'd0);
    check("abort_ny", bus.next_ypos, 4'd0);
    tick();
    check("abort_hold_out", {3'b0, bus.out}, 4'd0);
    reset = 1'b1;
    tick();
    check("abort_rel_out", {3'b0, bus.out}, 4'd0);
    check("abort_rel_nx", bus.next_xpos, 4'd6);
    tick();
    check("abort_rel_out2", {3'b0, bus.out}, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
